stall_ctrl: RTL
===============

Name: stall_ctrl

Overview:
- Hazard-detection and stall controller for the 5-stage MIPS pipeline. It is the producer-timing counterpart of the forwarding unit: forwarding steers data that is already available, and this block holds the pipeline when the data is not yet available.
- Decodes the D-stage instruction into Tuse/Tnew/A3. It keeps its own E- and M-stage shadow registers of Tnew/A3 and a mult/div busy counter.
- Outputs drive the PC enable, the D-register enable and the E-register clear.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu.
- DIV_CYCLES, 10, busy cycles loaded for div/divu.
- CNT_W, 4, busy-counter width; must hold DIV_CYCLES.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- IR_D  input  32  instruction in D stage (0 = nop).
- stall  output  1  1 = hold PC and IF/ID register.
- flush_E  output  1  1 = load bubble into ID/EX register; equals stall.
- md_busy  output  1  mult/div counter nonzero.
- md_start  output  1  one-cycle pulse: mult/div advancing D->E this edge.

Behaviour:
- Decode of IR_D (combinational):
  - addu/subu/and/or/slt: Tuse_rs=1, Tuse_rt=1, Tnew=1, A3=rd.
  - sll: Tuse_rt=1, Tnew=1, A3=rd.
  - ori/addiu/lui: Tuse_rs=1, Tnew=1, A3=rt.
  - lw: Tuse_rs=1, Tnew=2, A3=rt.
  - sw: Tuse_rs=1, Tuse_rt=2, no write.
  - beq: Tuse_rs=0, Tuse_rt=0.
  - jr: Tuse_rs=0.
  - jal: Tnew=0, A3=31.
  - j: no use, no write.
  - mult/multu/div/divu: Tuse_rs=1, Tuse_rt=1, no write, MD-class.
  - mthi/mtlo: Tuse_rs=1, MD-class.
  - mfhi/mflo: Tnew=1, A3=rd, MD-class.
  - Any unused operand: Tuse=3 (never stalls). Unknown opcode: no use, no write.
  - "No write" is encoded as A3=0, Tnew=0.
- Shadow registers: Tnew_E, A3_E, Tnew_M, A3_M (2b/5b each).
  - Every edge: Tnew_M <= (Tnew_E==0 ? 0 : Tnew_E-1); A3_M <= A3_E.
  - If stall=0: Tnew_E <= Tnew_D, A3_E <= A3_D. If stall=1: Tnew_E <= 0, A3_E <= 0 (bubble).
- Data stall: stall_data = OR over src in {rs,rt}, stage X in {E,M} of (IR_D[src]!=0 && IR_D[src]==A3_X && Tuse_src < Tnew_X).
  - Register $0 never causes a stall.
  - The W stage never causes a stall.
- MD counter cnt[CNT_W-1:0]:
  - Each edge: if md_start, load MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu). Otherwise, if cnt!=0, cnt <= cnt-1.
  - Counting continues regardless of stall.
  - md_busy = (cnt!=0).
  - md_start = IR_D is mult/multu/div/divu && !stall && !reset.
- MD stall: stall_md = IR_D is MD-class && md_busy.
- stall = (stall_data | stall_md) & !reset; flush_E = stall. All outputs are combinational from registered state and IR_D.
- Reset:
  - All shadow registers and cnt are cleared to 0 on the reset edge.
  - While reset=1: stall=0, flush_E=0, md_start=0; md_busy reflects cnt (0 after the first reset edge).
  - Reset asserted mid-multiply aborts the count.
- Resulting latencies:
  - lw -> dependent beq/jr: 2 stall cycles.
  - lw -> dependent ALU: 1 stall cycle.
  - ALU -> dependent beq/jr: 1 stall cycle.
  - lw -> sw using rt: 0 stall cycles (forwarded in M).
  - mult -> mflo: exactly MULT_CYCLES stall cycles.

Decomposition:
- Package mips_defs holds:
  - opcode/funct constants;
  - field-slice constants (Op, Rs, Rt, Rd, Func);
  - the A3sel encoding (00 rd, 01 rt, 10 rs, 11 $31) shared with the forwarding unit;
  - Tnew/Tuse widths.
- One sub-module: hazard_decode (pure combinational IR -> Tuse_rs, Tuse_rt, Tnew, A3, is_md, is_md_start, is_div).
- stall_ctrl holds the shadow registers, the counter and the compare logic.

Test Plan:
- lw $1,0($0) then beq $1,$2 -> stall=1 for 2 cycles, flush_E=1 both cycles, then beq advances.
- lw $1 then addu $3,$1,$2 -> stall=1 for 1 cycle. lw $1 then sw $1,4($0) -> stall never asserts.
- addu $0,$1,$2 then beq $0,$0 -> no stall. nop stream -> stall=0 throughout.
- mult $1,$2 then mflo $3 -> md_start pulses once, cnt=5, stall=1 for 5 cycles, mflo advances when cnt=0.
- div followed by an independent addu then mfhi -> addu not stalled; mfhi stalls until 10 cycles after the div's md_start.
- div issued, reset at cnt=6 -> cnt=0, md_busy=0, stall=0 next cycle, and a pending mflo advances immediately after reset.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants: opcode/funct values, instruction field slices,
// the A3 destination-select encoding and the Tnew/Tuse widths.
package mips_defs;
  localparam int TW = 2;
  localparam int RW = 5;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [1:0] {
    A3_RD = 2'b00,
    A3_RT = 2'b01,
    A3_RS = 2'b10,
    A3_RA = 2'b11
  } a3sel_t;

  localparam logic [RW-1:0] REG_ZERO  = 5'd0;
  localparam logic [RW-1:0] REG_RA    = 5'd31;
  localparam logic [TW-1:0] TUSE_NONE = 2'd3;
endpackage

// File: rtl/stall_ctrl_hazard_decode.sv
// Combinational decode of the D-stage instruction into operand-use times,
// result-ready time, destination register and mult/div class flags.
module hazard_decode
  import mips_defs::*;
(
  input  logic [31:0]   ir,
  output logic [TW-1:0] tuse_rs,
  output logic [TW-1:0] tuse_rt,
  output logic [TW-1:0] tnew,
  output logic [RW-1:0] a3,
  output logic          is_md,
  output logic          is_md_start,
  output logic          is_div
);
  logic [5:0] w_op;
  logic [5:0] w_func;
  logic       w_we;
  a3sel_t     w_a3sel;
  logic       w_unused_shamt;

  assign w_op           = ir[OP_HI:OP_LO];
  assign w_func         = ir[FUNC_HI:FUNC_LO];
  assign w_unused_shamt = ^ir[10:6];

  // Instruction class table; anything unrecognised neither reads nor writes.
  always_comb begin
    tuse_rs     = TUSE_NONE;
    tuse_rt     = TUSE_NONE;
    tnew        = 2'd0;
    w_we        = 1'b0;
    w_a3sel     = A3_RD;
    is_md       = 1'b0;
    is_md_start = 1'b0;
    is_div      = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_func)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
            tuse_rs = 2'd1; tuse_rt = 2'd1; tnew = 2'd1; w_we = 1'b1;
          end
          FN_SLL: begin
            tuse_rt = 2'd1; tnew = 2'd1; w_we = 1'b1;
          end
          FN_JR: tuse_rs = 2'd0;
          FN_MULT, FN_MULTU: begin
            tuse_rs = 2'd1; tuse_rt = 2'd1; is_md = 1'b1; is_md_start = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            tuse_rs = 2'd1; tuse_rt = 2'd1; is_md = 1'b1; is_md_start = 1'b1;
            is_div  = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs = 2'd1; is_md = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            tnew = 2'd1; w_we = 1'b1; is_md = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDIU, OP_LUI: begin
        tuse_rs = 2'd1; tnew = 2'd1; w_we = 1'b1; w_a3sel = A3_RT;
      end
      OP_LW: begin
        tuse_rs = 2'd1; tnew = 2'd2; w_we = 1'b1; w_a3sel = A3_RT;
      end
      OP_SW: begin
        tuse_rs = 2'd1; tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        tuse_rs = 2'd0; tuse_rt = 2'd0;
      end
      OP_JAL: begin
        w_we = 1'b1; w_a3sel = A3_RA;
      end
      OP_J:    ;
      default: ;
    endcase
  end

  // Destination mux; non-writers report $0 so they can never match a source.
  always_comb begin
    a3 = REG_ZERO;
    case (w_a3sel)
      A3_RD:   a3 = ir[RD_HI:RD_LO];
      A3_RT:   a3 = ir[RT_HI:RT_LO];
      A3_RS:   a3 = ir[RS_HI:RS_LO];
      A3_RA:   a3 = REG_RA;
      default: a3 = REG_ZERO;
    endcase
    a3 = w_we ? a3 : REG_ZERO;
  end
endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: tracks E/M producer timing and the
// mult/div busy counter, and holds the front end when an operand is late.
module stall_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic        md_start
);
  localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYCLES);

  logic [TW-1:0]    w_tuse_rs, w_tuse_rt, w_tnew_d;
  logic [RW-1:0]    w_a3_d, w_rs, w_rt;
  logic             w_is_md, w_is_md_start, w_is_div;
  logic             w_stall_data, w_stall_md;
  logic [TW-1:0]    r_tnew_e, r_tnew_m;
  logic [RW-1:0]    r_a3_e, r_a3_m;
  logic [CNT_W-1:0] r_cnt;

  hazard_decode u_decode (
    .ir          (IR_D),
    .tuse_rs     (w_tuse_rs),
    .tuse_rt     (w_tuse_rt),
    .tnew        (w_tnew_d),
    .a3          (w_a3_d),
    .is_md       (w_is_md),
    .is_md_start (w_is_md_start),
    .is_div      (w_is_div)
  );

  function automatic logic dep_hit(input logic [RW-1:0] src, input logic [TW-1:0] tuse,
                                   input logic [RW-1:0] a3x, input logic [TW-1:0] tnewx);
    return (src != REG_ZERO) && (src == a3x) && (tuse < tnewx);
  endfunction

  assign w_rs = IR_D[RS_HI:RS_LO];
  assign w_rt = IR_D[RT_HI:RT_LO];

  assign w_stall_data = dep_hit(w_rs, w_tuse_rs, r_a3_e, r_tnew_e)
                      | dep_hit(w_rs, w_tuse_rs, r_a3_m, r_tnew_m)
                      | dep_hit(w_rt, w_tuse_rt, r_a3_e, r_tnew_e)
                      | dep_hit(w_rt, w_tuse_rt, r_a3_m, r_tnew_m);
  assign w_stall_md   = w_is_md & md_busy;

  assign stall    = (w_stall_data | w_stall_md) & ~reset;
  assign flush_E  = stall;
  assign md_busy  = (r_cnt != '0);
  assign md_start = w_is_md_start & ~stall & ~reset;

  // Shadow E/M timing pipeline and mult/div countdown; a stall injects a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tnew_e <= '0;
      r_a3_e   <= '0;
      r_tnew_m <= '0;
      r_a3_m   <= '0;
      r_cnt    <= '0;
    end else begin
      r_tnew_m <= (r_tnew_e == '0) ? '0 : r_tnew_e - TW'(1);
      r_a3_m   <= r_a3_e;
      r_tnew_e <= stall ? '0 : w_tnew_d;
      r_a3_e   <= stall ? '0 : w_a3_d;
      if (md_start) begin
        r_cnt <= w_is_div ? L_DIV : L_MULT;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end
endmodule
